// File: rtl/sip_stream_feeder.sv
// Producer for the SIP data interface: tagged 16-bit host writes buffered in three per-stream FIFOs.
// Latency: write to output in 2 edges (push, auto-load); flush to new data in 1 edge. Host backpressure: wr_ready = target FIFO not full.

module sip_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // The extra pointer MSB separates full from empty when the index bits match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

module sip_stream_reg #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         fifo_empty,
  input  logic [W-1:0] fifo_rdata,
  output logic         pop,
  output logic [W-1:0] cur,
  output logic         valid,
  output logic         und_set
);
  logic [W-1:0] cur_q, cur_d;
  logic         valid_q, valid_d;

  // An empty output register refills itself; a flush always tries to advance.
  always_comb begin
    pop     = (flush || !valid_q) && !fifo_empty;
    und_set = flush && fifo_empty;
    cur_d   = pop ? fifo_rdata : cur_q;
    valid_d = valid_q;
    if (pop)        valid_d = 1'b1;
    else if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      valid_q <= valid_d;
    end
  end

  assign cur   = cur_q;
  assign valid = valid_q;
endmodule

module sip_stream_feeder #(
  parameter int N_SYN  = 16,
  parameter int W_BITS = 4,
  parameter int DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [1:0]              wr_sel,
  input  logic [15:0]             wr_data,
  input  logic                    flush_weight,
  input  logic                    flush_spike,
  input  logic                    flush_Ein,
  output logic [N_SYN*W_BITS-1:0] parallel_in_weight,
  output logic [N_SYN-1:0]        parallel_spike_in,
  output logic [N_SYN-1:0]        parallel_Ein,
  output logic                    weight_valid,
  output logic                    spike_valid,
  output logic                    Ein_valid,
  output logic                    underrun,
  input  logic                    underrun_clr
);
  localparam int WW = N_SYN * W_BITS;

  logic          w_full, w_empty, s_full, s_empty, e_full, e_empty;
  logic          w_pop, s_pop, e_pop;
  logic          w_und, s_und, e_und;
  logic          w_push, s_push, e_push, accept;
  logic [WW-1:0] w_rdata;
  logic [15:0]   s_rdata, e_rdata;

  logic [1:0]       beat_q, beat_d;
  logic [WW-17:0]   asm_q, asm_d;
  logic             underrun_q, underrun_d;

  always_comb begin
    case (wr_sel)
      2'd0:    wr_ready = !w_full;
      2'd1:    wr_ready = !s_full;
      2'd2:    wr_ready = !e_full;
      default: wr_ready = 1'b1;
    endcase
  end

  assign accept = wr_valid && wr_ready;
  assign w_push = accept && (wr_sel == 2'd0) && (beat_q == 2'd3);
  assign s_push = accept && (wr_sel == 2'd1);
  assign e_push = accept && (wr_sel == 2'd2);

  // Beats 0..2 collect in asm_q; beat 3 completes the frame straight from wr_data.
  always_comb begin
    beat_d = beat_q;
    asm_d  = asm_q;
    if (accept && (wr_sel == 2'd0)) begin
      beat_d = beat_q + 2'd1;
      case (beat_q)
        2'd0:    asm_d[15:0]  = wr_data;
        2'd1:    asm_d[31:16] = wr_data;
        2'd2:    asm_d[47:32] = wr_data;
        default: asm_d        = asm_q;
      endcase
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (w_und || s_und || e_und) underrun_d = 1'b1;
    else if (underrun_clr)       underrun_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_q     <= '0;
      asm_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;

  sip_fifo #(.W(WW), .DEPTH(DEPTH)) u_w_fifo (
    .clock(clock), .reset(reset), .push(w_push), .wdata({wr_data, asm_q}),
    .pop(w_pop), .rdata(w_rdata), .full(w_full), .empty(w_empty)
  );
  sip_fifo #(.W(16), .DEPTH(DEPTH)) u_s_fifo (
    .clock(clock), .reset(reset), .push(s_push), .wdata(wr_data),
    .pop(s_pop), .rdata(s_rdata), .full(s_full), .empty(s_empty)
  );
  sip_fifo #(.W(16), .DEPTH(DEPTH)) u_e_fifo (
    .clock(clock), .reset(reset), .push(e_push), .wdata(wr_data),
    .pop(e_pop), .rdata(e_rdata), .full(e_full), .empty(e_empty)
  );

  sip_stream_reg #(.W(WW)) u_w_reg (
    .clock(clock), .reset(reset), .flush(flush_weight), .fifo_empty(w_empty),
    .fifo_rdata(w_rdata), .pop(w_pop), .cur(parallel_in_weight),
    .valid(weight_valid), .und_set(w_und)
  );
  sip_stream_reg #(.W(16)) u_s_reg (
    .clock(clock), .reset(reset), .flush(flush_spike), .fifo_empty(s_empty),
    .fifo_rdata(s_rdata), .pop(s_pop), .cur(parallel_spike_in),
    .valid(spike_valid), .und_set(s_und)
  );
  sip_stream_reg #(.W(16)) u_e_reg (
    .clock(clock), .reset(reset), .flush(flush_Ein), .fifo_empty(e_empty),
    .fifo_rdata(e_rdata), .pop(e_pop), .cur(parallel_Ein),
    .valid(Ein_valid), .und_set(e_und)
  );
endmodule

// File: tb/tb_sip_stream_feeder.sv
// Bench for sip_stream_feeder: directed scenarios plus random traffic against a queue-based reference model.

module tb_sip_stream_feeder;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [1:0]  wr_sel = 2'd0;
  logic [15:0] wr_data = 16'h0;
  logic        flush_weight = 1'b0, flush_spike = 1'b0, flush_Ein = 1'b0;
  logic        underrun_clr = 1'b0;
  logic [63:0] parallel_in_weight;
  logic [15:0] parallel_spike_in, parallel_Ein;
  logic        weight_valid, spike_valid, Ein_valid, underrun;

  int n_checks = 0;
  int n_fails  = 0;

  sip_stream_feeder #(.N_SYN(16), .W_BITS(4), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .flush_weight(flush_weight),
    .flush_spike(flush_spike), .flush_Ein(flush_Ein),
    .parallel_in_weight(parallel_in_weight), .parallel_spike_in(parallel_spike_in),
    .parallel_Ein(parallel_Ein), .weight_valid(weight_valid), .spike_valid(spike_valid),
    .Ein_valid(Ein_valid), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clock = ~clock;

  // Reference model: frame queues, current frames, flags, beats collected so far.
  logic [63:0] q_w[$];
  logic [15:0] q_s[$], q_e[$];
  logic [63:0] m_w;
  logic [15:0] m_s, m_e;
  bit          mv_w, mv_s, mv_e, m_und;
  logic [15:0] beats[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input logic [1:0] sel);
    case (sel)
      2'd0:    return q_w.size() < DEPTH;
      2'd1:    return q_s.size() < DEPTH;
      2'd2:    return q_e.size() < DEPTH;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    q_w.delete(); q_s.delete(); q_e.delete(); beats.delete();
    m_w = '0; m_s = '0; m_e = '0;
    mv_w = 0; mv_s = 0; mv_e = 0; m_und = 0;
  endtask

  task automatic model_edge();
    bit acc, und_now;
    acc     = wr_valid && model_ready(wr_sel);
    und_now = 0;
    // Streams advance from what was queued before this edge's write lands.
    if ((flush_weight || !mv_w) && q_w.size() > 0) begin m_w = q_w.pop_front(); mv_w = 1; end
    else if (flush_weight) begin mv_w = 0; und_now = 1; end
    if ((flush_spike || !mv_s) && q_s.size() > 0) begin m_s = q_s.pop_front(); mv_s = 1; end
    else if (flush_spike) begin mv_s = 0; und_now = 1; end
    if ((flush_Ein || !mv_e) && q_e.size() > 0) begin m_e = q_e.pop_front(); mv_e = 1; end
    else if (flush_Ein) begin mv_e = 0; und_now = 1; end
    if (acc) begin
      case (wr_sel)
        2'd0: begin
          beats.push_back(wr_data);
          if (beats.size() == 4) begin
            q_w.push_back({beats[3], beats[2], beats[1], beats[0]});
            beats.delete();
          end
        end
        2'd1: q_s.push_back(wr_data);
        2'd2: q_e.push_back(wr_data);
        default: ;
      endcase
    end
    if (und_now) m_und = 1;
    else if (underrun_clr) m_und = 0;
  endtask

  task automatic compare_all();
    chk("weight", parallel_in_weight, m_w);
    chk("spike", {48'h0, parallel_spike_in}, {48'h0, m_s});
    chk("ein", {48'h0, parallel_Ein}, {48'h0, m_e});
    chk("weight_valid", {63'h0, weight_valid}, {63'h0, mv_w});
    chk("spike_valid", {63'h0, spike_valid}, {63'h0, mv_s});
    chk("ein_valid", {63'h0, Ein_valid}, {63'h0, mv_e});
    chk("underrun", {63'h0, underrun}, {63'h0, m_und});
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    chk("wr_ready", {63'h0, wr_ready}, {63'h0, model_ready(wr_sel)});
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic idle();
    wr_valid = 0; flush_weight = 0; flush_spike = 0; flush_Ein = 0; underrun_clr = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset = 0;
  endtask

  task automatic write(input logic [1:0] sel, input logic [15:0] data);
    idle();
    wr_valid = 1; wr_sel = sel; wr_data = data;
    cycle();
    idle();
  endtask

  initial begin
    @(negedge clock);
    do_reset();
    chk("reset_weight", parallel_in_weight, 64'h0);
    chk("reset_underrun", {63'h0, underrun}, 64'h0);

    // Basic frame load on all three streams.
    write(2'd0, 16'h3210); write(2'd0, 16'h7654); write(2'd0, 16'hBA98); write(2'd0, 16'hFEDC);
    write(2'd1, 16'hAAAA);
    write(2'd2, 16'hFFFF);
    cycle(); cycle();
    chk("load_weight", parallel_in_weight, 64'hFEDCBA9876543210);
    chk("load_spike", {48'h0, parallel_spike_in}, 64'hAAAA);
    chk("load_ein", {48'h0, parallel_Ein}, 64'hFFFF);
    chk("load_valids", {61'h0, weight_valid, spike_valid, Ein_valid}, 64'h7);
    chk("load_underrun", {63'h0, underrun}, 64'h0);

    // Spike flush alone advances only the spike stream.
    write(2'd1, 16'h5555);
    write(2'd2, 16'hAAAA);
    flush_spike = 1; cycle(); idle();
    chk("flush_spike", {48'h0, parallel_spike_in}, 64'h5555);
    chk("flush_spike_ein", {48'h0, parallel_Ein}, 64'hFFFF);
    chk("flush_spike_w", parallel_in_weight, 64'hFEDCBA9876543210);

    // Drain Ein, then flush it empty.
    flush_Ein = 1; cycle(); idle();
    chk("ein_second", {48'h0, parallel_Ein}, 64'hAAAA);
    flush_Ein = 1; cycle(); idle();
    chk("ein_hold", {48'h0, parallel_Ein}, 64'hAAAA);
    chk("ein_invalid", {63'h0, Ein_valid}, 64'h0);
    chk("underrun_set", {63'h0, underrun}, 64'h1);
    underrun_clr = 1; cycle(); idle();
    chk("underrun_clr", {63'h0, underrun}, 64'h0);

    // Fill the spike FIFO behind the current frame, then drain one per edge.
    for (int i = 0; i < DEPTH + 1; i++) begin
      idle(); wr_valid = 1; wr_sel = 2'd1; wr_data = 16'h1000 + 16'(i);
      #1;
      chk("spike_fill_ready", {63'h0, wr_ready}, {63'h0, (i < DEPTH)});
      cycle();
    end
    idle();
    flush_spike = 1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("spike_drain", {48'h0, parallel_spike_in}, 64'h1000 + 64'(i));
    end
    cycle();
    chk("spike_drain_under", {63'h0, underrun}, 64'h1);
    idle(); underrun_clr = 1; cycle(); idle();

    // Reset mid-assembly discards partial beats.
    write(2'd0, 16'h1111); write(2'd0, 16'h2222);
    do_reset();
    write(2'd0, 16'hCDEF); write(2'd0, 16'h89AB); write(2'd0, 16'h4567); write(2'd0, 16'h0123);
    cycle();
    chk("reset_reassembly", parallel_in_weight, 64'h0123456789ABCDEF);

    // Push and flush on an empty Ein FIFO in the same cycle.
    idle(); wr_valid = 1; wr_sel = 2'd2; wr_data = 16'h1234; flush_Ein = 1;
    cycle(); idle();
    chk("same_cycle_under", {63'h0, underrun}, 64'h1);
    chk("same_cycle_invalid", {63'h0, Ein_valid}, 64'h0);
    cycle();
    chk("same_cycle_load", {48'h0, parallel_Ein}, 64'h1234);
    chk("same_cycle_valid", {63'h0, Ein_valid}, 64'h1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        idle();
        do_reset();
      end
      wr_valid     = ($urandom_range(0, 1) == 1);
      wr_sel       = 2'($urandom_range(0, 3));
      wr_data      = 16'($urandom);
      flush_weight = ($urandom_range(0, 9) < 2);
      flush_spike  = ($urandom_range(0, 9) < 3);
      flush_Ein    = ($urandom_range(0, 9) < 3);
      underrun_clr = ($urandom_range(0, 9) == 0);
      cycle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
